// File: rtl/cr_lz77_comp_mob_pl.sv
// cr_lz77_comp_mob_pl: parametrised LZ77 match output builder with output FIFO, flush and sticky errors
module cr_lz77_comp_mob_pl #(
    parameter int LANES      = 4,
    parameter int LEN_W      = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int NTILES     = 128,
    localparam int CW        = $clog2(LANES + 2)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*8-1:0]     in_lit,
    input  logic [LANES-1:0]       in_lit_valid,
    input  logic [LANES-1:0]       in_emit_lit,
    input  logic                   in_emit_ptr,
    input  logic                   in_ptr_is_mtf,
    input  logic [LEN_W-1:0]       in_ptr_length,
    input  logic [LEN_W-1:0]       in_ptr_offset,
    input  logic [LEN_W-1:0]       in_mtf_idx,
    input  logic                   in_mim1,
    input  logic [LEN_W-1:0]       in_global_count,
    input  logic                   in_adjust_gc,
    input  logic                   in_last,
    input  logic [2:0]             win_size,
    output logic [NTILES-1:0]      tile_enable,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [(LANES+1)*2-1:0] out_type,
    output logic [LANES*8-1:0]     out_lit,
    output logic [CW-1:0]          out_count,
    output logic [LEN_W-1:0]       out_ptr_length,
    output logic [LEN_W-1:0]       out_ptr_offset,
    output logic                   out_last,
    output logic                   done,
    output logic [1:0]             err
);
    localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic                   last;
        logic [LEN_W-1:0]       off;
        logic [LEN_W-1:0]       len;
        logic [CW-1:0]          cnt;
        logic [LANES*8-1:0]     lit;
        logic [(LANES+1)*2-1:0] typ;
    } grp_t;

    logic                 s1_valid;
    logic [LANES*8-1:0]   s1_lit;
    logic [LANES-1:0]     s1_lit_valid;
    logic [LANES-1:0]     s1_emit_lit;
    logic                 s1_emit_ptr;
    logic                 s1_is_mtf;
    logic [LEN_W-1:0]     s1_length;
    logic [LEN_W-1:0]     s1_offset;
    logic [LEN_W-1:0]     s1_mtf_idx;
    logic                 s1_mim1;
    logic [LEN_W-1:0]     s1_gc;
    logic                 s1_adjust_gc;
    logic                 s1_last;

    grp_t                 g;
    grp_t                 mem [FIFO_DEPTH];
    grp_t                 head;
    int                   k;
    int                   n;
    logic [LEN_W-1:0]     gc_adj;
    logic [LEN_W:0]       sum;
    logic                 sat;
    logic                 und;
    logic                 push;
    logic                 pop;
    logic                 accept;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [FCW-1:0]       fifo_count;
    logic [NTILES-1:0]    te_next;

    assign in_ready = (int'(fifo_count) + int'(s1_valid)) < FIFO_DEPTH;
    assign accept   = in_valid && in_ready;
    assign out_valid = fifo_count != '0;
    assign pop      = out_valid && out_ready;
    assign push     = s1_valid && (g.cnt != '0 || s1_last);
    assign head     = mem[rd_ptr];

    // Empty FIFO presents an all-NULL group rather than stale storage
    assign out_type       = out_valid ? head.typ : '0;
    assign out_lit        = out_valid ? head.lit : '0;
    assign out_count      = out_valid ? head.cnt : '0;
    assign out_ptr_length = out_valid ? head.len : '0;
    assign out_ptr_offset = out_valid ? head.off : '0;
    assign out_last       = out_valid ? head.last : 1'b0;

    // Stage 1: capture the accepted beat
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid     <= 1'b0;
            s1_lit       <= '0;
            s1_lit_valid <= '0;
            s1_emit_lit  <= '0;
            s1_emit_ptr  <= 1'b0;
            s1_is_mtf    <= 1'b0;
            s1_length    <= '0;
            s1_offset    <= '0;
            s1_mtf_idx   <= '0;
            s1_mim1      <= 1'b0;
            s1_gc        <= '0;
            s1_adjust_gc <= 1'b0;
            s1_last      <= 1'b0;
        end else if (flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_lit       <= in_lit;
                s1_lit_valid <= in_lit_valid;
                s1_emit_lit  <= in_emit_lit;
                s1_emit_ptr  <= in_emit_ptr;
                s1_is_mtf    <= in_ptr_is_mtf;
                s1_length    <= in_ptr_length;
                s1_offset    <= in_ptr_offset;
                s1_mtf_idx   <= in_mtf_idx;
                s1_mim1      <= in_mim1;
                s1_gc        <= in_global_count;
                s1_adjust_gc <= in_adjust_gc;
                s1_last      <= in_last;
            end
        end
    end

    // Stage 2: compact literals, append pointer slot, finalise length and offset
    always_comb begin
        g = '0;
        k = 0;
        for (int i = 0; i < LANES; i++) begin
            if (s1_emit_lit[i] && s1_lit_valid[i]) begin
                g.lit[k*8 +: 8] = s1_lit[i*8 +: 8];
                g.typ[k*2 +: 2] = 2'd1;
                k = k + 1;
            end
        end
        gc_adj = s1_adjust_gc ? ((s1_gc > LEN_W'(LANES)) ? s1_gc - LEN_W'(LANES) : '0) : s1_gc;
        sum    = {1'b0, s1_length} + {1'b0, gc_adj};
        sat    = s1_emit_ptr && sum[LEN_W];
        und    = s1_emit_ptr && s1_is_mtf && s1_mim1 && (s1_mtf_idx == '0);
        if (s1_emit_ptr) begin
            g.typ[k*2 +: 2] = s1_is_mtf ? 2'd3 : 2'd2;
            g.len = sum[LEN_W] ? '1 : sum[LEN_W-1:0];
            g.off = s1_is_mtf ? (und ? '0 : s1_mtf_idx - LEN_W'(s1_mim1)) : s1_offset;
        end
        g.cnt  = CW'(k + int'(s1_emit_ptr));
        g.last = s1_last;
    end

    // FIFO storage; validity is tracked by the pointers and count below
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr] <= g;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= (wr_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            if (pop) rd_ptr <= (rd_ptr == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            fifo_count <= fifo_count + FCW'(push) - FCW'(pop);
        end
    end

    // Sticky error flags survive flush, only reset clears them
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= '0;
        else if (s1_valid && !flush) err <= err | {und, sat};
    end

    // done drops on a new stream and rises once its last group leaves
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) done <= 1'b1;
        else if (flush) done <= 1'b1;
        else if (accept) done <= 1'b0;
        else if (pop && out_last) done <= 1'b1;
    end

    // Tile enable count from window code, clamped and filled from tile 0 up
    always_comb begin
        n = (win_size == 3'd0) ? 1 : (win_size <= 3'd4) ? (4 << win_size) : NTILES;
        if (n > NTILES) n = NTILES;
        te_next = '0;
        for (int i = 0; i < NTILES; i++) te_next[i] = i < n;
    end

    // Tile enables are re-registered every cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tile_enable <= '0;
        else if (flush) tile_enable <= '0;
        else tile_enable <= te_next;
    end
endmodule

// File: doc/cr_lz77_comp_mob_pl.md
Name: cr_lz77_comp_mob_pl

Overview:
Parametrised, back-pressured match output builder for the LZ77 compressor. Per accepted beat it takes the match state machine's emit decisions, aligned literals and one pointer/MTF candidate. It packs the selected literals and the pointer into a symbol group, finalises pointer length and MTF index, and buffers groups in an output FIFO with valid/ready toward the encoder. Unlike the fixed 4-lane builder, lane count, field width and buffer depth are parameters, and the block supports downstream stall, flush and error flags.

Parameters:
LANES, 4, literal lanes per beat; output group has LANES+1 symbol slots
LEN_W, 12, width of length/offset/MTF index/global count
FIFO_DEPTH, 4, output FIFO entries (>=2)
NTILES, 128, number of history tiles driven by tile_enable

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of pipeline and FIFO
in_valid  in  1  input beat valid
in_ready  out  1  block can accept a beat
in_lit  in  LANES*8  literal bytes, lane 0 = oldest
in_lit_valid  in  LANES  literal byte present
in_emit_lit  in  LANES  emit literal on lane i
in_emit_ptr  in  1  emit pointer/MTF after literals
in_ptr_is_mtf  in  1  pointer is MTF reference
in_ptr_length  in  LEN_W  base match length
in_ptr_offset  in  LEN_W  match offset
in_mtf_idx  in  LEN_W  MTF index
in_mim1  in  1  decrement MTF index by one
in_global_count  in  LEN_W  global match count
in_adjust_gc  in  1  subtract LANES from global count
in_last  in  1  final beat of stream
win_size  in  3  history window code
tile_enable  out  NTILES  registered tile enables
out_valid  out  1  group valid
out_ready  in  1  consumer accepts group
out_type  out  (LANES+1)*2  slot types, lz77_symbol_type_e (NULL=0, LIT=1, PTR=2, MTF=3)
out_lit  out  LANES*8  compacted literals, slot 0 first
out_count  out  $clog2(LANES+2)  symbols in group
out_ptr_length  out  LEN_W  final length
out_ptr_offset  out  LEN_W  offset or adjusted MTF index
out_last  out  1  final group of stream
done  out  1  idle / stream complete
err  out  2  sticky: [0] length saturated, [1] MTF underflow

Behaviour:
- Reset and flush give: out_valid=0, all out_* = 0/NULL, done=1, err=0, FIFO empty, stage-1 empty, tile_enable=0. Flush does not clear err. Flush wins over a simultaneous accept.
- Accept = in_valid && in_ready. Accepted fields are registered into stage 1 (s1).
- in_ready = (fifo_count + s1_valid) < FIFO_DEPTH. The FIFO never overflows, and a group is never dropped while out_ready=0.
- Stage 2 is combinational from s1 and writes to the FIFO the cycle after accept:
  - Literal selection: a lane qualifies if in_emit_lit[i] && in_lit_valid[i]. Qualifying lanes are packed in ascending lane order into slots 0..k-1 with type LIT. Unused literal bytes are 0.
  - Pointer slot: if emit_ptr, slot k gets type PTR, or MTF when is_mtf. count = k + emit_ptr.
  - Length: gc_adj = adjust_gc ? gc - LANES (floor at 0) : gc. sum = length + gc_adj in LEN_W+1 bits. If the carry is set, output all ones and set err[0].
  - Offset: if MTF, use mtf_idx - mim1; if mim1 && mtf_idx==0, output 0 and set err[1]. Otherwise use ptr_offset. If no pointer is emitted, length and offset are 0.
  - A group with count=0 and !last is not written. A group with count=0 and last is written with all slots NULL and out_last=1.
- FIFO is a registered first-word-fall-through. Empty-FIFO latency is accept at N, out_valid at N+2. A pop (out_valid && out_ready) and a push in the same cycle are legal when full.
- done falls on the first accept after done=1. done rises the cycle after the out_last group is popped.
- tile_enable is registered every cycle from win_size, independent of handshakes:
  - 0 → 1 tile
  - 1..4 → (4<<win_size) tiles (8, 16, 32, 64)
  - any other code → all NTILES tiles
  - lowest tiles are enabled first; the enabled count is clamped to NTILES.
- Asynchronous reset mid-stream discards all buffered groups immediately.

Test Plan:
- Reset, then emit_lit=4'b1011, all lit_valid, lits 0x41..0x44, emit_ptr=0 → one group: count=3, out_lit slots = 0x41, 0x42, 0x44, types LIT,LIT,LIT,NULL,NULL, out_valid at accept+2.
- emit_lit=4'b0001, emit_ptr, length=5, gc=10, adjust_gc=1 → count=2, types LIT,PTR, out_ptr_length=11.
- is_mtf, mtf_idx=3, mim1=1 → slot0 MTF, offset=2. Then mtf_idx=0, mim1=1 → offset=0 and err[1]=1 stays set until reset.
- Hold out_ready=0 and stream 6 beats → in_ready low after 4 buffered (s1 included). Release → all 6 groups arrive in order with none lost.
- emit_lit=0, emit_ptr=0 beat, then a same-empty beat with in_last=1 → only one group: count=0, out_last=1. done=1 one cycle after its pop.
- win_size sweep 0..7 → tile_enable popcount 1, 8, 16, 32, 64, 128, 128, 128. Assert flush with a full FIFO → out_valid=0 next cycle and done=1.
